// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline sequencer.
//   state_e   : controller FSM encoding (also exported on the debug state port)
//   NOP_INSTR : the bubble word the datapath loads when a register is flushed
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A source register creates a load-use dependency only when it is
  // actually read and names the destination of the load in E.
  function automatic logic src_hit(input logic use_src, input logic match);
    return use_src & match;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and enable/flush outputs to the five
// pipeline registers (PC, F/D, D/E, E/M, M/W).
//   master : datapath side (drives hazard info, receives en/flush)
//   slave  : controller side
interface pipeline_ctrl_if #(
  parameter int REG_AW = 5
) ();
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              ex_pc_src;
  logic              mem_req;
  logic              mem_ready;

  logic en_pc, en_fd, en_de, en_em, en_mw;
  logic flush_fd, flush_de, flush_em, flush_mw;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_pc_src, mem_req, mem_ready,
    input  en_pc, en_fd, en_de, en_em, en_mw,
           flush_fd, flush_de, flush_em, flush_mw
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_pc_src, mem_req, mem_ready,
    output en_pc, en_fd, en_de, en_em, en_mw,
           flush_fd, flush_de, flush_em, flush_mw
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset (q -> 0)
//   clr        : synchronous clear (q -> 0), below reset in priority
//   inc        : count up by one; holds at all-ones instead of wrapping
//   q          : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Enable/flush sequencer for the 5-stage RV32I pipeline.
// Resolves load-use stalls, taken branch/jump flushes and data-memory waits,
// with a watchdog that parks the core in ERROR if memory never answers.
//   clk, reset   : single clock, synchronous active-high reset
//   bus          : hazard inputs / register en+flush outputs (slave modport)
//   mem_err      : sticky watchdog error (high while in ERROR)
//   state        : FSM state, debug only
//   stall_cycles : saturating count of cycles with en_pc low
// en/flush are combinational from state and inputs; FSM and counters are
// registered.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e r_state;
  state_e w_next;

  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  logic              w_lu, w_mw;
  logic [4:0]        w_en;     // {pc, fd, de, em, mw}
  logic [3:0]        w_flush;  // {fd, de, em, mw}
  logic [TO_W-1:0]   w_to_cnt;
  logic              w_to_clr, w_to_inc;

  assign w_rs1 = bus.id_rs1;
  assign w_rs2 = bus.id_rs2;
  assign w_rd  = bus.ex_rd;

  // x0 is never a real destination, so a load to x0 cannot cause a hazard.
  assign w_lu = bus.ex_is_load && (w_rd != '0) &&
                (src_hit(bus.id_use_rs1, w_rs1 == w_rd) ||
                 src_hit(bus.id_use_rs2, w_rs2 == w_rd));

  // In MEM_WAIT a dropped mem_req is treated as completion, which is what
  // this expression yields naturally.
  assign w_mw = bus.mem_req && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_en    = 5'b11111;
    w_flush = 4'b0000;

    unique case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mw) begin
          // Freeze everything up to E/M and bubble into M/W; branch and
          // load-use are re-evaluated once memory releases.
          w_en    = 5'b00001;
          w_flush = 4'b0001;
          if (r_state == ST_RUN) begin
            w_next = ST_MEM_WAIT;
          end else if (w_to_cnt == TO_LAST) begin
            w_next = ST_ERROR;
          end
        end else begin
          w_next = ST_RUN;
          if (bus.ex_pc_src) begin
            w_flush = 4'b1100;
          end else if (w_lu) begin
            w_en    = 5'b00111;
            w_flush = 4'b0100;
          end
        end
      end
      ST_ERROR: begin
        w_en    = 5'b00000;
        w_flush = 4'b1111;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase

    if (reset) begin
      w_en    = 5'b00000;
      w_flush = 4'b1111;
    end
  end

  assign {bus.en_pc, bus.en_fd, bus.en_de, bus.en_em, bus.en_mw} = w_en;
  assign {bus.flush_fd, bus.flush_de, bus.flush_em, bus.flush_mw} = w_flush;

  // Watchdog counts only consecutive non-ready MEM_WAIT cycles.
  assign w_to_inc = (r_state == ST_MEM_WAIT) && w_mw;
  assign w_to_clr = !w_to_inc;

  sat_counter #(.W(TO_W)) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clr  (w_to_clr),
    .inc  (w_to_inc),
    .q    (w_to_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (!w_en[4]),
    .q    (stall_cycles)
  );

  assign mem_err = (r_state == ST_ERROR);
  assign state   = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       clk;
  logic       reset;
  logic       mem_err;
  logic [1:0] state;
  logic [2:0] stall_cycles;

  pipeline_ctrl_if #(.REG_AW(5)) bus ();

  pipeline_ctrl #(
    .REG_AW     (5),
    .MEM_TIMEOUT(4),
    .TO_W       (3),
    .CNT_W      (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mem_err     (mem_err),
    .state       (state),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] en;
    logic [3:0] fl;
    bit         chk;
    logic [1:0] st;
    logic       err;
    logic [2:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Drive one cycle of inputs just after the edge and queue what the DUT
  // must show during that cycle.
  // in_v = {reset, ex_is_load, ex_pc_src, mem_req, mem_ready, use_rs1, use_rs2}
  task automatic step(input string nm, input logic [6:0] in_v,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd,
                      input logic [4:0] e_en, input logic [3:0] e_fl,
                      input bit chk, input logic [1:0] e_st,
                      input logic e_err, input logic [2:0] e_stall);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = in_v[6];
    bus.ex_is_load = in_v[5];
    bus.ex_pc_src  = in_v[4];
    bus.mem_req    = in_v[3];
    bus.mem_ready  = in_v[2];
    bus.id_use_rs1 = in_v[1];
    bus.id_use_rs2 = in_v[0];
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.ex_rd      = rd;
    e.name = nm; e.en = e_en; e.fl = e_fl; e.chk = chk;
    e.st = e_st; e.err = e_err; e.stall = e_stall;
    exp_q.push_back(e);
  endtask

  // Monitor: compares on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] a_en;
      logic [3:0] a_fl;
      e = exp_q.pop_front();
      a_en = {bus.en_pc, bus.en_fd, bus.en_de, bus.en_em, bus.en_mw};
      a_fl = {bus.flush_fd, bus.flush_de, bus.flush_em, bus.flush_mw};
      checks++;
      if (a_en !== e.en) begin
        failures++;
        $display("FAIL %s en actual=%b expected=%b", e.name, a_en, e.en);
      end
      checks++;
      if (a_fl !== e.fl) begin
        failures++;
        $display("FAIL %s flush actual=%b expected=%b", e.name, a_fl, e.fl);
      end
      if (e.chk) begin
        checks++;
        if (state !== e.st) begin
          failures++;
          $display("FAIL %s state actual=%0d expected=%0d", e.name, state, e.st);
        end
        checks++;
        if (mem_err !== e.err) begin
          failures++;
          $display("FAIL %s mem_err actual=%b expected=%b", e.name, mem_err, e.err);
        end
        checks++;
        if (stall_cycles !== e.stall) begin
          failures++;
          $display("FAIL %s stall_cycles actual=%0d expected=%0d", e.name, stall_cycles, e.stall);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [6:0] RST  = 7'b1000000;
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] LU1  = 7'b0100010;  // load + use rs1
  localparam logic [6:0] LU2  = 7'b0100001;  // load + use rs2
  localparam logic [6:0] LD_N = 7'b0100000;  // load, no source used
  localparam logic [6:0] BRLU = 7'b0110010;  // branch + load-use
  localparam logic [6:0] MW   = 7'b0001000;  // mem_req, not ready
  localparam logic [6:0] MRDY = 7'b0001100;  // mem_req, ready
  localparam logic [6:0] MWBR = 7'b0011000;  // mem wait + branch
  localparam logic [6:0] BR   = 7'b0010000;  // branch, mem_req dropped
  localparam logic [6:0] RDY  = 7'b0000100;  // mem_ready only

  initial begin
    reset = 1'b1;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rd = '0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_is_load = 1'b0; bus.ex_pc_src = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

    // reset held 3 cycles
    step("rst0",  RST,  0, 0, 0, 5'b00000, 4'b1111, 0, 0, 0, 0);
    step("rst1",  RST,  0, 0, 0, 5'b00000, 4'b1111, 1, 0, 0, 0);
    step("rst2",  RST,  0, 0, 0, 5'b00000, 4'b1111, 1, 0, 0, 0);
    step("idle0", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 0);

    // load-use
    step("lu_rs1",   LU1,  5, 0, 5, 5'b00111, 4'b0100, 1, 0, 0, 0);
    step("lu_after", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 1);
    step("lu_x0",    LU1,  0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 1);
    step("lu_rs2",   LU2,  3, 7, 7, 5'b00111, 4'b0100, 1, 0, 0, 1);
    step("lu_nouse", LD_N, 7, 7, 7, 5'b11111, 4'b0000, 1, 0, 0, 2);
    step("lu_diff",  LU1,  6, 0, 5, 5'b11111, 4'b0000, 1, 0, 0, 2);

    // branch beats load-use
    step("br_lu",    BRLU, 5, 0, 5, 5'b11111, 4'b1100, 1, 0, 0, 2);
    step("br_after", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 2);

    // memory wait: 3 not-ready cycles, then ready
    step("rst_m",  RST,  0, 0, 0, 5'b00000, 4'b1111, 1, 0, 0, 2);
    step("mw0",    MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 0, 0, 0);
    step("mw1",    MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 1, 0, 1);
    step("mw2",    MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 1, 0, 2);
    step("mw_rel", MRDY, 0, 0, 0, 5'b11111, 4'b0000, 1, 1, 0, 3);
    step("mw_end", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 3);
    step("zw",     MRDY, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 3);
    step("zw_end", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 3);

    // wait hides branch; dropped mem_req releases and branch then acts
    step("mwbr",     MWBR, 0, 0, 0, 5'b00001, 4'b0001, 1, 0, 0, 3);
    step("drop_br",  BR,   0, 0, 0, 5'b11111, 4'b1100, 1, 1, 0, 4);
    step("drop_end", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 4);

    // watchdog: MEM_TIMEOUT=4, never ready
    step("rst_t", RST,  0, 0, 0, 5'b00000, 4'b1111, 1, 0, 0, 4);
    step("to0",   MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 0, 0, 0);
    step("to1",   MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 1, 0, 1);
    step("to2",   MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 1, 0, 2);
    step("to3",   MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 1, 0, 3);
    step("to4",   MW,   0, 0, 0, 5'b00001, 4'b0001, 1, 1, 0, 4);
    step("err0",  MW,   0, 0, 0, 5'b00000, 4'b1111, 1, 2, 1, 5);
    step("err1",  RDY,  0, 0, 0, 5'b00000, 4'b1111, 1, 2, 1, 6);
    step("err2",  IDLE, 0, 0, 0, 5'b00000, 4'b1111, 1, 2, 1, 7);
    step("err3",  IDLE, 0, 0, 0, 5'b00000, 4'b1111, 1, 2, 1, 7);
    step("err_rst", RST, 0, 0, 0, 5'b00000, 4'b1111, 1, 2, 1, 7);
    step("err_clr", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 0);

    // stall counter saturation (CNT_W=3)
    for (int k = 0; k < 10; k++) begin
      logic [2:0] s;
      s = (k > 7) ? 3'd7 : 3'(k);
      step("sat", LU1, 9, 0, 9, 5'b00111, 4'b0100, 1, 0, 0, s);
    end
    step("sat_end", IDLE, 0, 0, 0, 5'b11111, 4'b0000, 1, 0, 0, 7);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
